// File: rtl/pwm_duty_meter.sv
// Measures high time and period of an asynchronous PWM input and derives a normalised duty
// value with a restoring divider. Also flags a stuck line and dropped captures.
module pwm_duty_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DUTY_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  input  logic              clr,
  output logic [CNT_W-1:0]  meas_high,
  output logic [CNT_W-1:0]  meas_period,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              stuck_level,
  output logic              overrun
);

  localparam int unsigned IterW = $clog2(DUTY_W);
  localparam logic [IterW-1:0] LastIter = IterW'(DUTY_W - 1);
  localparam logic [CNT_W-1:0] PerLimit = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StWait, StHigh, StLow} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   level, armed, rise, fall;

  // warm_q gates edge detection until the synchroniser and prev_q hold real samples, so a
  // line already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign armed = warm_q[SYNC_STAGES];
  assign rise  = armed & level & ~prev_q;
  assign fall  = armed & ~level & prev_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
  logic             capture, timeout;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    per_d   = per_q;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      StWait: begin
        if (rise) begin
          state_d = StHigh;
          hi_d    = CntOne;
          per_d   = CntOne;
        end
      end
      StHigh: begin
        per_d = per_q + 1'b1;
        if (level) hi_d = hi_q + 1'b1;
        if (per_q == PerLimit) begin
          timeout = 1'b1;
          state_d = StWait;
        end else if (fall) begin
          state_d = StLow;
        end
      end
      StLow: begin
        if (rise) begin
          capture = 1'b1;
          hi_d    = CntOne;
          per_d   = CntOne;
          state_d = StHigh;
        end else if (per_q == PerLimit) begin
          timeout = 1'b1;
          state_d = StWait;
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      default: state_d = StWait;
    endcase
    if (clr) begin
      state_d = StWait;
      hi_d    = '0;
      per_d   = '0;
      capture = 1'b0;
      timeout = 1'b0;
    end
  end

  logic              busy_q, busy_d;
  logic [IterW-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    rem_q, rem_d, shifted;
  logic [DUTY_W-1:0] quo_q, quo_d, quo_next;
  logic [CNT_W-1:0]  cap_hi_q, cap_hi_d, cap_per_q, cap_per_d;
  logic [CNT_W-1:0]  meas_high_q, meas_high_d, meas_period_q, meas_period_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d, stuck_q, stuck_d, lvl_q, lvl_d, ovr_q, ovr_d;
  logic              ge;

  // Remainder starts at hi < per, so each step yields one quotient bit of hi * 2^DUTY_W / per.
  assign shifted  = {rem_q[CNT_W-1:0], 1'b0};
  assign ge       = shifted >= {1'b0, cap_per_q};
  assign quo_next = {quo_q[DUTY_W-2:0], ge};

  always_comb begin
    busy_d        = busy_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cap_hi_d      = cap_hi_q;
    cap_per_d     = cap_per_q;
    meas_high_d   = meas_high_q;
    meas_period_d = meas_period_q;
    duty_d        = duty_q;
    valid_d       = 1'b0;
    stuck_d       = stuck_q;
    lvl_d         = lvl_q;
    ovr_d         = ovr_q;
    if (busy_q) begin
      rem_d = ge ? (shifted - {1'b0, cap_per_q}) : shifted;
      quo_d = quo_next;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastIter) begin
        busy_d        = 1'b0;
        valid_d       = 1'b1;
        meas_high_d   = cap_hi_q;
        meas_period_d = cap_per_q;
        duty_d        = quo_next;
        stuck_d       = 1'b0;
      end
    end
    if (capture) begin
      if (busy_q) begin
        ovr_d = 1'b1;
      end else begin
        busy_d    = 1'b1;
        cnt_d     = '0;
        rem_d     = {1'b0, hi_q};
        quo_d     = '0;
        cap_hi_d  = hi_q;
        cap_per_d = per_q;
      end
    end
    if (timeout) begin
      stuck_d = 1'b1;
      lvl_d   = level;
    end
    if (clr) begin
      busy_d        = 1'b0;
      valid_d       = 1'b0;
      meas_high_d   = '0;
      meas_period_d = '0;
      duty_d        = '0;
      stuck_d       = 1'b0;
      lvl_d         = 1'b0;
      ovr_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StWait;
      hi_q          <= '0;
      per_q         <= '0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cap_hi_q      <= '0;
      cap_per_q     <= '0;
      meas_high_q   <= '0;
      meas_period_q <= '0;
      duty_q        <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      lvl_q         <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      per_q         <= per_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cap_hi_q      <= cap_hi_d;
      cap_per_q     <= cap_per_d;
      meas_high_q   <= meas_high_d;
      meas_period_q <= meas_period_d;
      duty_q        <= duty_d;
      valid_q       <= valid_d;
      stuck_q       <= stuck_d;
      lvl_q         <= lvl_d;
      ovr_q         <= ovr_d;
    end
  end

  assign meas_high   = meas_high_q;
  assign meas_period = meas_period_q;
  assign duty        = duty_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = lvl_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomised and directed bench for pwm_duty_meter: a waveform-level model predicts each valid
// (values and arrival cycle) into a scoreboard; a second 8-bit-counter instance covers timeout.
module tb_pwm_duty_meter;

  localparam int DUTY_W = 8;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + DUTY_W;
  localparam int MAXP   = (1 << 16) - 2;

  logic        clk = 1'b0;
  logic        rst_n, pwm_in, clr;
  logic [15:0] meas_high, meas_period;
  logic [7:0]  duty;
  logic        valid, stuck, stuck_level, overrun;

  logic        pwm8, clr8;
  logic [7:0]  meas_high8, meas_period8, duty8;
  logic        valid8, stuck8, stuck_level8, overrun8;

  always #5 clk = ~clk;

  pwm_duty_meter #(.CNT_W(16), .DUTY_W(DUTY_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .clr(clr),
    .meas_high(meas_high), .meas_period(meas_period), .duty(duty), .valid(valid),
    .stuck(stuck), .stuck_level(stuck_level), .overrun(overrun)
  );

  pwm_duty_meter #(.CNT_W(8), .DUTY_W(DUTY_W), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm8), .clr(clr8),
    .meas_high(meas_high8), .meas_period(meas_period8), .duty(duty8), .valid(valid8),
    .stuck(stuck8), .stuck_level(stuck_level8), .overrun(overrun8)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Waveform-level reference: each rising edge closes the previous period; the divider is
  // free again DUTY_W+1 cycles after an accepted capture.
  typedef struct {int hi; int per; int duty; int cyc;} exp_t;
  exp_t sb[$];
  exp_t e;
  bit   m_seen, m_has_acc, m_ovr;
  int   m_prev_r, m_prev_h, m_last_acc;

  task automatic model_reset();
    m_seen    = 0;
    m_has_acc = 0;
    m_ovr     = 0;
  endtask

  task automatic model_rise(input int r, input int h);
    int p;
    p = r - m_prev_r;
    if (m_seen && p <= MAXP) begin
      if (m_has_acc && (r - m_last_acc) < DUTY_W + 1) begin
        m_ovr = 1;
      end else begin
        sb.push_back('{hi: m_prev_h, per: p, duty: (m_prev_h * (1 << DUTY_W)) / p, cyc: r + LAT});
        m_has_acc  = 1;
        m_last_acc = r;
      end
    end
    m_seen   = 1;
    m_prev_r = r;
    m_prev_h = h;
  endtask

  task automatic rise_evt(input int h);
    @(negedge clk);
    model_rise(cyc + 1, h);
    pwm_in = 1'b1;
  endtask

  task automatic pulse(input int h, input int lo);
    rise_evt(h);
    repeat (h - 1) begin @(negedge clk); pwm_in = 1'b1; end
    repeat (lo) begin @(negedge clk); pwm_in = 1'b0; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); pwm_in = 1'b0; end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_meas_high"}, meas_high, 0);
    chk({tag, "_meas_period"}, meas_period, 0);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_stuck"}, stuck, 0);
    chk({tag, "_stuck_level"}, stuck_level, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    chk_zero("clr");
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_valid: got valid at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("meas_high", meas_high, e.hi);
        chk("meas_period", meas_period, e.per);
        chk("duty", duty, e.duty);
      end
    end
  end

  // Background generator for the 8-bit instance: period 50, high 10; can park high after a rise.
  int gen8_mode = 0;
  bit gen8_hold_req = 0;
  int ph8 = 0;
  int last_rise8 = 0;

  always @(negedge clk) begin
    if (gen8_mode == 1) begin
      if (ph8 == 0) begin
        last_rise8 = cyc + 1;
        if (gen8_hold_req) gen8_mode = 2;
      end
      pwm8 = (ph8 < 10);
      ph8  = (ph8 == 49) ? 0 : ph8 + 1;
    end else if (gen8_mode == 2) begin
      pwm8 = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nv, t_exp;
    bit prev_stuck;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    clr    = 1'b0;
    pwm8   = 1'b0;
    clr8   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Timeout on the 8-bit instance.
    ph8       = 0;
    gen8_mode = 1;
    nv = 0;
    n  = 0;
    while (nv < 3 && n < 400) begin @(negedge clk); n++; if (valid8) nv++; end
    chk("dut8_valids_seen", nv, 3);
    chk("dut8_duty", duty8, 51);
    gen8_hold_req = 1;
    n = 0;
    while (gen8_mode != 2 && n < 100) begin @(negedge clk); n++; end
    chk("dut8_hold_reached", gen8_mode, 2);
    t_exp = last_rise8 + SYNC + 254;
    n = 0;
    while (cyc < t_exp - 1 && n < 400) begin @(negedge clk); n++; end
    chk("dut8_stuck_early", stuck8, 0);
    @(negedge clk);
    chk("dut8_stuck_set", stuck8, 1);
    chk("dut8_stuck_level", stuck_level8, 1);
    chk("dut8_duty_held", duty8, 51);
    gen8_hold_req = 0;
    ph8           = 10;
    gen8_mode     = 1;
    prev_stuck    = stuck8;
    n = 0;
    while (!valid8 && n < 300) begin prev_stuck = stuck8; @(negedge clk); n++; end
    chk("dut8_resume_valid", valid8, 1);
    chk("dut8_stuck_before_valid", prev_stuck, 1);
    chk("dut8_stuck_cleared", stuck8, 0);
    chk("dut8_meas_high", meas_high8, 10);
    chk("dut8_meas_period", meas_period8, 50);
    gen8_mode = 0;
    pwm8      = 1'b0;

    // Directed periods.
    idle(10);
    repeat (4) pulse(25, 75);
    repeat (3) pulse(99, 1);
    repeat (3) pulse(1, 999);
    pulse(25, 75);
    drain();
    chk("overrun_directed", overrun, 0);

    // Random periods, including some shorter than the divider latency.
    for (int i = 0; i < 60; i++) begin
      int p, h;
      p = $urandom_range(40, 2);
      h = $urandom_range(p - 1, 1);
      pulse(h, p - h);
    end
    pulse(1, 20);
    drain();
    chk("overrun_random", overrun, m_ovr);

    // Short period forces drops; clr must wipe everything.
    do_clr();
    repeat (12) pulse(2, 3);
    pulse(1, 20);
    drain();
    chk("overrun_short", overrun, 1);
    do_clr();
    repeat (3) pulse(25, 75);
    drain();

    // Async reset while high and with a divide in flight; line stays high through release.
    repeat (2) pulse(25, 75);
    rise_evt(25);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    idle(20);
    repeat (3) pulse(25, 75);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Receive-side counterpart to the PWM generators that drive the RGB LED channels.
- Samples one asynchronous PWM waveform, for example looped back from an LED pin or taken from an external source.
- Measures high time and period in clk cycles and computes a normalised duty value with a sequential divider.
- Flags a stuck line (no edges) and measurement overrun. Instantiated once per channel.

Parameters:
- CNT_W, 16: width of the high-time and period counters and outputs.
- DUTY_W, 8: width of the duty result; also the divider iteration count.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser (minimum 2).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- pwm_in  in  1  asynchronous PWM input.
- clr  in  1  synchronous clear of measurement state and flags.
- meas_high  out  CNT_W  high cycles in the last completed period.
- meas_period  out  CNT_W  cycles between the last two rising edges.
- duty  out  DUTY_W  floor(meas_high * 2^DUTY_W / meas_period).
- valid  out  1  one-cycle pulse when meas_high, meas_period and duty update.
- stuck  out  1  no rising edge seen within timeout.
- stuck_level  out  1  synchronised pwm_in level when stuck was set.
- overrun  out  1  sticky; a capture was dropped because the divider was busy.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs, synchroniser flops, counters, divider and FSM clear to 0 / S_WAIT.
- Sync: pwm_in passes through SYNC_STAGES flops. Edges are detected by comparing the synchroniser output with a further registered copy. A pin edge is seen SYNC_STAGES+1 cycles later.
- FSM states:
  - S_WAIT: ignore the partial period. On a rising edge go to S_HIGH, with hi_cnt=1 and per_cnt=1.
  - S_HIGH: each cycle per_cnt++, and hi_cnt++ while the synced level is high. On a falling edge go to S_LOW.
  - S_LOW: per_cnt++. On a rising edge, capture hi_cnt/per_cnt as a completed period, reload hi_cnt=1 and per_cnt=1, go to S_HIGH.
- Capture timing: the period counts the edge cycle itself, so meas_period equals the true period in clk cycles. hi_cnt < per_cnt always, because low time is at least 1.
- Divider:
  - Restoring, one quotient bit per cycle, DUTY_W cycles, started the cycle after capture.
  - Captured values are held internally. meas_high, meas_period, duty and valid all update together DUTY_W+1 cycles after the capture cycle.
  - No saturation is needed, since duty ≤ 2^DUTY_W-1.
- Overrun: a capture arriving while the divider is busy is dropped. The counters still reload and the FSM continues, and overrun sets (sticky until clr or reset). Periods ≥ DUTY_W+1 cycles are always tracked.
- Timeout:
  - If per_cnt reaches 2^CNT_W-1 in S_HIGH or S_LOW, set stuck=1, latch stuck_level from the synced level, and go to S_WAIT.
  - The maximum measurable period is 2^CNT_W-2.
  - meas_*, duty and valid are unaffected.
  - stuck clears on the next valid pulse.
- clr: has priority over edge events in the same cycle. Returns the FSM to S_WAIT, aborts the divider (no valid) and clears meas_high, meas_period, duty, stuck, stuck_level and overrun. Synchroniser flops are not cleared.
- Reset mid-operation: the in-flight divide is discarded. The first valid after release needs two fresh rising edges.
- Level at start: pwm_in already high at reset release is not treated as a rising edge.

Test Plan:
- Period 100, high 25 (CNT_W=16, DUTY_W=8) -> first valid 9 cycles after the second detected rising edge; meas_high=25, meas_period=100, duty=64; valid every 100 cycles thereafter.
- Period 100, high 99 -> duty=253. Period 1000, high 1 -> duty=0, meas_high=1, meas_period=1000.
- CNT_W=8: run period 50 / high 10, then hold pwm_in high -> stuck=1 and stuck_level=1 exactly 254 cycles after the last rising edge; duty stays 51. Resume period 50 -> stuck clears on the first new valid.
- Period 5, high 2 (< DUTY_W+1) -> overrun=1; valid at most once per 10 cycles with duty=102. Assert clr -> overrun=0 and all outputs 0; valid resumes only after two rising edges.
- Pull rst_n low mid-S_HIGH and mid-divide -> all outputs 0 immediately (asynchronous); no valid from the aborted divide.
- Hold pwm_in high through reset release, first falling edge at +30 -> no valid until after a full rising-to-rising period.
